// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory loader: size defaults, header
// byte width and FSM state encoding.
package imem_pkg;

  localparam int DEPTH_DEF  = 64;
  localparam int ADDR_W_DEF = 6;
  localparam int HDR_W      = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_HDR    = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_WRITE  = 3'd3;
  localparam state_t S_FINISH = 3'd4;

endpackage

// File: rtl/byte_packer.sv
// Assembles four stream bytes into one little-endian 32-bit word.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] byte_cnt;

  // Shifting right lands the first byte of the word in bits 7:0 after four bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      word     <= 32'd0;
    end else if (clr) begin
      byte_cnt <= 2'd0;
      word     <= 32'd0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      word     <= {byte_in, word[31:8]};
    end
  end

  assign word_valid = byte_valid && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory while holding
// the core, then pulses done (or raises a sticky err).
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | waiting for start, core released
// S_HDR    | accepting the word-count header byte
// S_DATA   | accepting the bytes of the current word
// S_WRITE  | one-cycle write strobe of the assembled word
// S_FINISH | one-cycle done pulse
module imem_loader #(
  parameter int DEPTH  = imem_pkg::DEPTH_DEF,
  parameter int ADDR_W = imem_pkg::ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  import imem_pkg::*;

  localparam logic [HDR_W:0] DEPTH_HDR = (HDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   word_cnt_nxt;
  logic [ADDR_W:0]   n_q;
  logic [ADDR_W-1:0] hold_addr;
  logic [31:0]       hold_data;
  logic [31:0]       word;
  logic              word_valid;
  logic              accept;
  logic              hdr_big;

  // abort gates the handshake and the strobe in the same cycle it arrives.
  assign in_ready     = ((state == S_HDR) || (state == S_DATA)) && !abort;
  assign accept       = in_valid && in_ready;
  assign wr_en        = (state == S_WRITE) && !abort;
  assign cpu_hold     = (state != S_IDLE);
  assign done         = (state == S_FINISH);
  assign wr_addr      = wr_en ? word_cnt[ADDR_W-1:0] : hold_addr;
  assign wr_data      = wr_en ? word : hold_data;
  assign word_cnt_nxt = word_cnt + (ADDR_W+1)'(1);
  assign hdr_big      = {1'b0, in_byte} > DEPTH_HDR;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        ((state == S_IDLE) && start),
    .byte_valid ((state == S_DATA) && accept),
    .byte_in    (in_byte),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_addr <= '0;
      hold_data <= 32'd0;
    end else if (wr_en) begin
      hold_addr <= word_cnt[ADDR_W-1:0];
      hold_data <= word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      word_cnt <= '0;
      n_q      <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_HDR;
            err      <= 1'b0;
            word_cnt <= '0;
            n_q      <= '0;
          end
        end
        S_HDR: begin
          if (abort) begin
            state <= S_IDLE;
            err   <= 1'b1;
          end else if (accept) begin
            if (in_byte == 8'd0) begin
              state <= S_FINISH;
            end else if (hdr_big) begin
              state <= S_IDLE;
              err   <= 1'b1;
            end else begin
              n_q   <= (ADDR_W+1)'(in_byte);
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (abort) begin
            state <= S_IDLE;
            err   <= 1'b1;
          end else if (word_valid) begin
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (abort) begin
            state <= S_IDLE;
            err   <= 1'b1;
          end else begin
            word_cnt <= word_cnt_nxt;
            state    <= (word_cnt_nxt == n_q) ? S_FINISH : S_DATA;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
